// File: rtl/conv_encoder_framer.sv
// rtl/conv_encoder_framer.sv - rate-1/2 K=7 convolutional encoder with frame/tail sequencing (optional macro: CONV_ENC_TERMINATE_EN)
module conv_encoder_framer #(
   parameter int             FRAME_LEN = 512,
   parameter int             TAIL_LEN  = 32,
   parameter int             K         = 7,
   parameter logic [K-1:0]   G0        = 7'o171,
   parameter logic [K-1:0]   G1        = 7'o133
) (
   input  logic       clk,
   input  logic       RSTn,
   input  logic       d_in_valid,
   input  logic       d_in,
   output logic       d_in_ready,
   output logic       d_out_valid,
   output logic [1:0] d_out,
   output logic       frame_done
);

   localparam int BCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN + 1) : 1;
   localparam int TCW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN + 1) : 1;

   localparam logic [BCW-1:0] LAST_BIT  = BCW'(FRAME_LEN - 1);
   localparam logic [TCW-1:0] LAST_TAIL = TCW'(TAIL_LEN - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_TAIL = 2'd2;

`ifdef CONV_ENC_TERMINATE_EN
   // Termination needs room for K-1 flushing symbols inside the tail.
   if (TAIL_LEN < K - 1) begin : g_tail_too_short
      $error("conv_encoder_framer: TAIL_LEN must be >= K-1 when CONV_ENC_TERMINATE_EN is defined");
   end
`endif

   logic [1:0]     state_q, state_d;
   logic [K-2:0]   sr_q, sr_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic [TCW-1:0] tail_cnt_q, tail_cnt_d;
   logic [1:0]     d_out_q, d_out_d;
   logic           d_out_valid_q, d_out_valid_d;
   logic           frame_done_q, frame_done_d;
   logic           accept;

   // Window is {current bit, past bits}; sr[K-2] holds the most recent past bit.
   function automatic logic [1:0] encode(input logic b, input logic [K-2:0] s);
      logic [K-1:0] w;
      w = {b, s};
      return {^(w & G1), ^(w & G0)};
   endfunction

   assign d_in_ready = (state_q != S_TAIL);
   assign accept     = d_in_valid & d_in_ready;

   // Next-state: consume data bits, then run the fixed-length tail.
   always_comb begin
      state_d       = state_q;
      sr_d          = sr_q;
      bit_cnt_d     = bit_cnt_q;
      tail_cnt_d    = tail_cnt_q;
      d_out_d       = d_out_q;
      d_out_valid_d = 1'b0;
      frame_done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DATA: begin
            if (accept) begin
               d_out_d       = encode(d_in, sr_q);
               d_out_valid_d = 1'b1;
               sr_d          = {d_in, sr_q[K-2:1]};
               // bit_cnt is 0 in IDLE, so FRAME_LEN==1 goes straight to TAIL.
               if (bit_cnt_q == LAST_BIT) begin
                  state_d   = S_TAIL;
                  bit_cnt_d = '0;
               end else begin
                  state_d   = S_DATA;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_TAIL: begin
            d_out_valid_d = 1'b1;
`ifdef CONV_ENC_TERMINATE_EN
            if (int'(tail_cnt_q) < K - 1) begin
               d_out_d = encode(1'b0, sr_q);
               sr_d    = {1'b0, sr_q[K-2:1]};
            end else begin
               d_out_d = 2'b00;
            end
`else
            d_out_d = 2'b00;
`endif
            if (tail_cnt_q == LAST_TAIL) begin
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
               tail_cnt_d   = '0;
               sr_d         = '0;
            end else begin
               tail_cnt_d = tail_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = S_IDLE;
            sr_d       = '0;
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state_q       <= S_IDLE;
         sr_q          <= '0;
         bit_cnt_q     <= '0;
         tail_cnt_q    <= '0;
         d_out_q       <= 2'b00;
         d_out_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         sr_q          <= sr_d;
         bit_cnt_q     <= bit_cnt_d;
         tail_cnt_q    <= tail_cnt_d;
         d_out_q       <= d_out_d;
         d_out_valid_q <= d_out_valid_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign d_out       = d_out_q;
   assign d_out_valid = d_out_valid_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// tb/tb_conv_encoder_framer.sv - self-checking bench for conv_encoder_framer
module tb_conv_encoder_framer;

   localparam int N = 512;
   localparam int T = 32;
   localparam int K = 7;
   localparam logic [6:0] GEN0 = 7'o171;
   localparam logic [6:0] GEN1 = 7'o133;

   logic       clk = 1'b0;
   logic       RSTn = 1'b0;
   logic       d_in_valid = 1'b0;
   logic       d_in = 1'b0;
   logic       d_in_ready;
   logic       d_out_valid;
   logic [1:0] d_out;
   logic       frame_done;

   conv_encoder_framer dut (
      .clk        (clk),
      .RSTn       (RSTn),
      .d_in_valid (d_in_valid),
      .d_in       (d_in),
      .d_in_ready (d_in_ready),
      .d_out_valid(d_out_valid),
      .d_out      (d_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         din;
      logic [1:0] dout;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_acc_cyc = 0;
   int rdy_low_n = 0;
   int rdy_low_first = -1;
   int rdy_bad = 0;
   int fd_stray = 0;

   bit         frame_bits[$];
   logic [1:0] exp_q[$];
   logic [1:0] cap_q[$];
   bit         fd_q[$];
   logic [1:0] last_cap[$];
   logic [1:0] gapless_cap[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: collects every valid symbol and tracks ready-low cycles.
   always @(negedge clk) begin
      if (RSTn) begin
         if (d_out_valid) begin
            cap_q.push_back(d_out);
            fd_q.push_back(frame_done);
         end else if (frame_done) begin
            fd_stray++;
         end
         if (!d_in_ready) begin
            if (rdy_low_n == 0) rdy_low_first = cyc;
            rdy_low_n++;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: each symbol is the mod-2 convolution of the input sequence
   // (zero history at frame start) with the generators; tail inputs are zeros.
   task automatic build_model();
      bit         ext[$];
      logic [6:0] g0;
      logic [6:0] g1;
      logic [1:0] s;
      bit         live;
      g0 = GEN0;
      g1 = GEN1;
      ext = frame_bits;
      for (int i = 0; i < T; i++) ext.push_back(1'b0);
      exp_q.delete();
      for (int t = 0; t < N + T; t++) begin
         s = 2'b00;
         live = (t < N);
`ifdef CONV_ENC_TERMINATE_EN
         live = live || (t < N + K - 1);
`endif
         if (live) begin
            for (int j = 0; j < K; j++) begin
               if (t - j >= 0) begin
                  s[0] = s[0] ^ (g0[K-1-j] & ext[t-j]);
                  s[1] = s[1] ^ (g1[K-1-j] & ext[t-j]);
               end
            end
         end
         exp_q.push_back(s);
      end
   endtask

   task automatic clear_capture();
      cap_q.delete();
      fd_q.delete();
      rdy_low_n = 0;
      rdy_low_first = -1;
      rdy_bad = 0;
      fd_stray = 0;
   endtask

   task automatic do_reset(input string tag);
      RSTn = 1'b0;
      d_in_valid = 1'b1;
      d_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({tag, " d_out_valid"}, int'(d_out_valid), 0);
      chk({tag, " d_out"}, int'(d_out), 0);
      chk({tag, " d_in_ready"}, int'(d_in_ready), 1);
      chk({tag, " frame_done"}, int'(frame_done), 0);
      d_in_valid = 1'b0;
      RSTn = 1'b1;
      clear_capture();
   endtask

   task automatic drive_bits(input bit gaps);
      bit acc;
      bit v;
      clear_capture();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         acc = 1'b0;
         while (!acc) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            d_in_valid = v;
            d_in = v ? frame_bits[i] : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!d_in_ready) rdy_bad++;
            if (v) begin
               acc = 1'b1;
               last_acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
         end
      end
      d_in_valid = 1'b0;
   endtask

   // Valid stays high through the tail; those bits must be ignored.
   task automatic hold_tail();
      repeat (T) begin
         d_in_valid = 1'b1;
         d_in = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      d_in_valid = 1'b0;
   endtask

   task automatic check_frame(input string tag);
      int waited;
      int bad;
      int fdn;
      waited = 0;
      bad = -1;
      fdn = 0;
      while (cap_q.size() < N + T && waited < 3000) begin
         @(negedge clk);
         #1;
         waited++;
      end
      repeat (4) @(negedge clk);
      #1;
      build_model();
      chk({tag, " symbol count"}, cap_q.size(), N + T);
      for (int i = 0; i < cap_q.size() && i < N + T; i++)
         if (cap_q[i] !== exp_q[i] && bad < 0) bad = i;
      chk({tag, " first bad symbol index"}, bad, -1);
      foreach (fd_q[i]) if (fd_q[i]) fdn++;
      chk({tag, " frame_done count"}, fdn + fd_stray, 1);
      chk({tag, " frame_done on last symbol"},
          (fd_q.size() >= N + T) ? int'(fd_q[N+T-1]) : -1, 1);
      chk({tag, " ready low cycles"}, rdy_low_n, T);
      chk({tag, " ready low start"}, rdy_low_first, last_acc_cyc + 1);
      chk({tag, " ready low during data"}, rdy_bad, 0);
      chk({tag, " sr cleared"}, int'(dut.sr_q), 0);
      last_cap = cap_q;
      clear_capture();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[7];
      int   diff;
      int   waited;
      tbl[0] = '{1'b1, 2'b11};
      tbl[1] = '{1'b0, 2'b01};
      tbl[2] = '{1'b0, 2'b11};
      tbl[3] = '{1'b0, 2'b11};
      tbl[4] = '{1'b0, 2'b00};
      tbl[5] = '{1'b0, 2'b10};
      tbl[6] = '{1'b0, 2'b11};

      // Reset with d_in_valid asserted
      do_reset("reset");

      // Impulse response, one symbol per cycle, registered latency
      for (int i = 0; i < 7; i++) begin
         d_in_valid = 1'b1;
         d_in = tbl[i].din;
         if (i == 0) begin
            #1;
            chk("impulse no output before accept", int'(d_out_valid), 0);
         end
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("impulse valid %0d", i), int'(d_out_valid), 1);
         chk($sformatf("impulse symbol %0d", i), int'(d_out), int'(tbl[i].dout));
      end
      d_in_valid = 1'b0;
      @(negedge clk);
      chk("gap valid low", int'(d_out_valid), 0);
      chk("gap d_out held", int'(d_out), 3);
      do_reset("reset after impulse");

      // Full frame, random bits, back-to-back
      frame_bits.delete();
      for (int i = 0; i < N; i++) frame_bits.push_back(1'($urandom_range(0, 1)));
      drive_bits(1'b0);
      hold_tail();
      check_frame("full");
      gapless_cap = last_cap;

      // Same bits with random input gaps
      drive_bits(1'b1);
      hold_tail();
      check_frame("gaps");
      diff = (last_cap.size() == gapless_cap.size()) ? 0 : 1;
      foreach (gapless_cap[i]) if (i < last_cap.size() && last_cap[i] !== gapless_cap[i]) diff++;
      chk("gaps equals gapless", diff, 0);

      // Reset during the tail, then a new frame
      frame_bits.delete();
      for (int i = 0; i < N; i++) frame_bits.push_back(1'($urandom_range(0, 1)));
      drive_bits(1'b0);
      waited = 0;
      while (cap_q.size() < N + 10 && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk("tail symbol 10 reached", int'(cap_q.size() >= N + 10), 1);
      RSTn = 1'b0;
      #1;
      chk("midreset d_out_valid", int'(d_out_valid), 0);
      chk("midreset d_out", int'(d_out), 0);
      chk("midreset d_in_ready", int'(d_in_ready), 1);
      chk("midreset frame_done", int'(frame_done), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      RSTn = 1'b1;
      clear_capture();
      repeat (5) @(negedge clk);
      #1;
      chk("no residual symbols", cap_q.size(), 0);
      frame_bits.delete();
      frame_bits.push_back(1'b1);
      for (int i = 1; i < N; i++) frame_bits.push_back(1'($urandom_range(0, 1)));
      drive_bits(1'b0);
      chk("new frame first symbol", (cap_q.size() > 0) ? int'(cap_q[0]) : -1, 3);
      hold_tail();
      check_frame("after reset");

      // All-ones frame: exercises termination from sr=111111 when enabled
      frame_bits.delete();
      for (int i = 0; i < N; i++) frame_bits.push_back(1'b1);
      drive_bits(1'b0);
      hold_tail();
      check_frame("all ones");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
